// File: rtl/passive_alarm_seq.sv
// Passive-security buzzer sequencer: debounces the warning, beeps a bounded on/off
// pattern, honours driver mute. Optional re-arm from MUTED under PASSIVE_ALARM_REARM_EN.
module passive_alarm_seq #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int BEEP_ON_CYC  = 8,
    parameter int BEEP_OFF_CYC = 8,
    parameter int MAX_BEEPS    = 3,
    parameter int CNT_W        = 4,
    parameter int REARM_CYC    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PassiveSignal,
    input  logic             Acknowledge,
    output logic             Buzzer,
    output logic             AlarmActive,
    output logic             Muted,
    output logic [CNT_W-1:0] BeepCount
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_QUALIFY  = 3'd1;
    localparam logic [2:0] S_BEEP_ON  = 3'd2;
    localparam logic [2:0] S_BEEP_OFF = 3'd3;
    localparam logic [2:0] S_MUTED    = 3'd4;

    localparam int PH_A = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
    localparam int PH_B = (PH_A > DEBOUNCE_CYC) ? PH_A : DEBOUNCE_CYC;
`ifdef PASSIVE_ALARM_REARM_EN
    localparam int PH_MAX = (PH_B > REARM_CYC) ? PH_B : REARM_CYC;
`else
    localparam int PH_MAX = PH_B + (REARM_CYC * 0);
`endif
    localparam int PW = $clog2(PH_MAX + 1);

    localparam logic [PW-1:0]    CNT_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0]    CNT_ONE   = PW'(1);
    localparam logic [PW-1:0]    DEB_LAST  = PW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0]    ON_LAST   = PW'(BEEP_ON_CYC - 1);
    localparam logic [PW-1:0]    OFF_LAST  = PW'(BEEP_OFF_CYC - 1);
`ifdef PASSIVE_ALARM_REARM_EN
    localparam logic [PW-1:0]    REARM_LAST = PW'(REARM_CYC - 1);
`endif
    localparam logic [CNT_W-1:0] BEEP_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] BEEP_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BEEP_LIM  = CNT_W'(MAX_BEEPS);

    logic [2:0]       r_state;
    logic [PW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_beeps;
    logic             r_buzzer;
    logic             r_active;
    logic             r_muted;

    logic [2:0]       w_state_nxt;
    logic [PW-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0] w_beeps_nxt;
    logic [CNT_W-1:0] w_beep_inc;
    logic             w_limit_hit;

    // Saturating beep increment and auto-mute detection for the beep just completed.
    always_comb begin
        if (r_beeps == BEEP_MAX) begin
            w_beep_inc = r_beeps;
        end else begin
            w_beep_inc = r_beeps + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        w_limit_hit = (MAX_BEEPS != 0) && (w_beep_inc == BEEP_LIM);
    end

    // Next-state, shared phase counter and beep count; deassertion outranks mute.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beeps_nxt = r_beeps;
        case (r_state)
            S_IDLE: begin
                w_beeps_nxt = BEEP_ZERO;
                if (PassiveSignal) begin
                    w_state_nxt = S_QUALIFY;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            S_QUALIFY: begin
                if (!PassiveSignal) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = S_BEEP_ON;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_BEEP_ON: begin
                if (!PassiveSignal) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_beeps_nxt = BEEP_ZERO;
                end else if (Acknowledge) begin
                    w_state_nxt = S_MUTED;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == ON_LAST) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_beeps_nxt = w_beep_inc;
                    if (w_limit_hit) begin
                        w_state_nxt = S_MUTED;
                    end else begin
                        w_state_nxt = S_BEEP_OFF;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_BEEP_OFF: begin
                if (!PassiveSignal) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_beeps_nxt = BEEP_ZERO;
                end else if (Acknowledge) begin
                    w_state_nxt = S_MUTED;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == OFF_LAST) begin
                    w_state_nxt = S_BEEP_ON;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_MUTED: begin
                if (!PassiveSignal) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_beeps_nxt = BEEP_ZERO;
`ifdef PASSIVE_ALARM_REARM_EN
                end else if (r_cnt == REARM_LAST) begin
                    w_state_nxt = S_BEEP_ON;
                    w_cnt_nxt   = CNT_ZERO;
                    w_beeps_nxt = BEEP_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
`else
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
                w_beeps_nxt = BEEP_ZERO;
            end
        endcase
    end

    // State registers; outputs decoded from the next state so they switch with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= CNT_ZERO;
            r_beeps  <= BEEP_ZERO;
            r_buzzer <= 1'b0;
            r_active <= 1'b0;
            r_muted  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_beeps  <= w_beeps_nxt;
            r_buzzer <= (w_state_nxt == S_BEEP_ON);
            r_active <= (w_state_nxt == S_BEEP_ON) || (w_state_nxt == S_BEEP_OFF);
            r_muted  <= (w_state_nxt == S_MUTED);
        end
    end

    assign Buzzer      = r_buzzer;
    assign AlarmActive = r_active;
    assign Muted       = r_muted;
    assign BeepCount   = r_beeps;

endmodule
